// File: rtl/control_pipeline_if.sv
// control_pipeline_if: decoded ID-stage controls in, staged controls and hazard/branch steering out.
interface control_pipeline_if #(parameter int REG_W = 5);
  logic             RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID;
  logic             MemRead_ID, MemWrite_ID, Branch_ID;
  logic [2:0]       ALUOp_ID;
  logic [REG_W-1:0] Rs_ID, Rt_ID, Rd_ID;
  logic             Zero_EX;
  logic             RegDst_EX, ALUSrc_EX;
  logic [2:0]       ALUOp_EX;
  logic             MemRead_MEM, MemWrite_MEM;
  logic             MemtoReg_WB, RegWrite_WB;
  logic [REG_W-1:0] WriteReg_WB;
  logic             PCSrc, PCWrite, IFIDWrite, IFIDFlush;
  modport master (
    output RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID,
           ALUOp_ID, Rs_ID, Rt_ID, Rd_ID, Zero_EX,
    input  RegDst_EX, ALUSrc_EX, ALUOp_EX, MemRead_MEM, MemWrite_MEM, MemtoReg_WB, RegWrite_WB,
           WriteReg_WB, PCSrc, PCWrite, IFIDWrite, IFIDFlush
  );
  modport slave (
    input  RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID,
           ALUOp_ID, Rs_ID, Rt_ID, Rd_ID, Zero_EX,
    output RegDst_EX, ALUSrc_EX, ALUOp_EX, MemRead_MEM, MemWrite_MEM, MemtoReg_WB, RegWrite_WB,
           WriteReg_WB, PCSrc, PCWrite, IFIDWrite, IFIDFlush
  );
endinterface

// File: rtl/control_pipeline.sv
// control_pipeline: ID/EX, EX/MEM, MEM/WB control staging with load-use stall and branch flush.
module control_pipeline #(parameter int REG_W = 5) (
  input  logic clk,
  input  logic reset,
  control_pipeline_if.slave bus
);
  typedef struct packed {
    logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [2:0] alu_op;
    logic [REG_W-1:0] rt, rd;
  } idex_t;
  typedef struct packed {
    logic mem_read, mem_write, mem_to_reg, reg_write;
    logic [REG_W-1:0] write_reg;
  } exmem_t;
  typedef struct packed {
    logic mem_to_reg, reg_write;
    logic [REG_W-1:0] write_reg;
  } memwb_t;
  idex_t            id_b, idex_d, idex_q;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;
  logic [REG_W-1:0] write_reg_ex;
  logic             pc_src, hazard, stall;
  always_comb begin
    write_reg_ex = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    pc_src = idex_q.branch & bus.Zero_EX;
    hazard = idex_q.mem_read && write_reg_ex != '0 &&
             (write_reg_ex == bus.Rs_ID ||
              (write_reg_ex == bus.Rt_ID && (!bus.ALUSrc_ID || bus.MemWrite_ID)));
    // a taken branch squashes the ID instruction anyway, so it overrides the stall
    stall = hazard & ~pc_src;
    id_b = '{reg_dst: bus.RegDst_ID, alu_src: bus.ALUSrc_ID, mem_to_reg: bus.MemtoReg_ID,
             reg_write: bus.RegWrite_ID, mem_read: bus.MemRead_ID, mem_write: bus.MemWrite_ID,
             branch: bus.Branch_ID, alu_op: bus.ALUOp_ID, rt: bus.Rt_ID, rd: bus.Rd_ID};
    idex_d = (stall || pc_src) ? '0 : id_b;
    exmem_d = '{mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                mem_to_reg: idex_q.mem_to_reg, reg_write: idex_q.reg_write,
                write_reg: write_reg_ex};
    memwb_d = '{mem_to_reg: exmem_q.mem_to_reg, reg_write: exmem_q.reg_write,
                write_reg: exmem_q.write_reg};
  end
  always_ff @(posedge clk) begin
    idex_q  <= reset ? idex_d  : '0;
    exmem_q <= reset ? exmem_d : '0;
    memwb_q <= reset ? memwb_d : '0;
  end
  assign bus.RegDst_EX    = idex_q.reg_dst;
  assign bus.ALUSrc_EX    = idex_q.alu_src;
  assign bus.ALUOp_EX     = idex_q.alu_op;
  assign bus.MemRead_MEM  = exmem_q.mem_read;
  assign bus.MemWrite_MEM = exmem_q.mem_write;
  assign bus.MemtoReg_WB  = memwb_q.mem_to_reg;
  assign bus.RegWrite_WB  = memwb_q.reg_write;
  assign bus.WriteReg_WB  = memwb_q.write_reg;
  assign bus.PCSrc        = pc_src;
  assign bus.PCWrite      = ~stall;
  assign bus.IFIDWrite    = ~stall;
  assign bus.IFIDFlush    = pc_src;
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed vectors with hand-computed expectations for control_pipeline.
module tb_control_pipeline;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  control_pipeline_if #(.REG_W(5)) bus ();
  control_pipeline #(.REG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  localparam logic [6:0] NOP   = 7'b0000000;
  localparam logic [6:0] RTYPE = 7'b1001000;
  localparam logic [6:0] LW    = 7'b0111100;
  localparam logic [6:0] SW    = 7'b0100010;
  localparam logic [6:0] BEQ   = 7'b0000001;
  localparam logic [6:0] LWBR  = 7'b0100101;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic id(input logic [6:0] c, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd);
    {bus.RegDst_ID, bus.ALUSrc_ID, bus.MemtoReg_ID, bus.RegWrite_ID,
     bus.MemRead_ID, bus.MemWrite_ID, bus.Branch_ID} = c;
    bus.ALUOp_ID = op;
    bus.Rs_ID = rs;
    bus.Rt_ID = rt;
    bus.Rd_ID = rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    bus.Zero_EX = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    bus.Zero_EX = 1'b0;
    tick();
    tick();
    chk("rst_aluop_ex", 32'(bus.ALUOp_EX), 32'd0);
    chk("rst_regwrite_wb", 32'(bus.RegWrite_WB), 32'd0);
    chk("rst_memwrite_mem", 32'(bus.MemWrite_MEM), 32'd0);
    chk("rst_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("rst_ifidwrite", 32'(bus.IFIDWrite), 32'd1);
    chk("rst_pcsrc", 32'(bus.PCSrc), 32'd0);
    chk("rst_flush", 32'(bus.IFIDFlush), 32'd0);
    reset = 1'b1;
    tick();
    // R-type latency through the stages
    id(RTYPE, 3'b111, 5'd2, 5'd3, 5'd9);
    tick();
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("r_aluop_ex", 32'(bus.ALUOp_EX), 32'd7);
    chk("r_regdst_ex", 32'(bus.RegDst_EX), 32'd1);
    tick();
    chk("r_regwrite_wb_early", 32'(bus.RegWrite_WB), 32'd0);
    tick();
    chk("r_regwrite_wb", 32'(bus.RegWrite_WB), 32'd1);
    chk("r_writereg_wb", 32'(bus.WriteReg_WB), 32'd9);
    chk("r_aluop_ex_after", 32'(bus.ALUOp_EX), 32'd0);
    drain();
    // load-use stall on Rs
    id(LW, 3'd0, 5'd1, 5'd8, 5'd0);
    #1 chk("lw_no_stall_yet", 32'(bus.PCWrite), 32'd1);
    tick();
    id(RTYPE, 3'b111, 5'd8, 5'd4, 5'd10);
    #1;
    chk("lu_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("lu_ifidwrite", 32'(bus.IFIDWrite), 32'd0);
    chk("lu_flush", 32'(bus.IFIDFlush), 32'd0);
    tick();
    chk("lu_pcwrite_one_cycle", 32'(bus.PCWrite), 32'd1);
    chk("lu_ifidwrite_one_cycle", 32'(bus.IFIDWrite), 32'd1);
    chk("lu_bubble_regdst", 32'(bus.RegDst_EX), 32'd0);
    chk("lu_bubble_alusrc", 32'(bus.ALUSrc_EX), 32'd0);
    chk("lu_bubble_aluop", 32'(bus.ALUOp_EX), 32'd0);
    chk("lu_lw_memread_mem", 32'(bus.MemRead_MEM), 32'd1);
    tick();
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("lu_consumer_aluop", 32'(bus.ALUOp_EX), 32'd7);
    chk("lu_wb1_regwrite", 32'(bus.RegWrite_WB), 32'd1);
    chk("lu_wb1_writereg", 32'(bus.WriteReg_WB), 32'd8);
    chk("lu_wb1_memtoreg", 32'(bus.MemtoReg_WB), 32'd1);
    tick();
    chk("lu_wb2_bubble", 32'(bus.RegWrite_WB), 32'd0);
    tick();
    chk("lu_wb3_regwrite", 32'(bus.RegWrite_WB), 32'd1);
    chk("lu_wb3_writereg", 32'(bus.WriteReg_WB), 32'd10);
    drain();
    // Rt-path hazard qualification with LW to r8 in EX
    id(LW, 3'd0, 5'd1, 5'd8, 5'd0);
    tick();
    id(7'b0101000, 3'd0, 5'd0, 5'd8, 5'd0);
    #1 chk("rt_imm_no_stall", 32'(bus.PCWrite), 32'd1);
    id(RTYPE, 3'b111, 5'd0, 5'd8, 5'd11);
    #1 chk("rt_reg_stall", 32'(bus.PCWrite), 32'd0);
    id(SW, 3'd0, 5'd0, 5'd8, 5'd0);
    #1 chk("rt_sw_stall", 32'(bus.PCWrite), 32'd0);
    drain();
    // load to r0 never stalls
    id(LW, 3'd0, 5'd1, 5'd0, 5'd0);
    tick();
    id(RTYPE, 3'b111, 5'd0, 5'd0, 5'd12);
    #1 chk("r0_no_stall", 32'(bus.PCWrite), 32'd1);
    drain();
    // taken branch
    id(BEQ, 3'b100, 5'd1, 5'd2, 5'd0);
    tick();
    chk("beq_aluop_ex", 32'(bus.ALUOp_EX), 32'd4);
    id(RTYPE, 3'b111, 5'd3, 5'd4, 5'd5);
    bus.Zero_EX = 1'b1;
    #1;
    chk("beq_pcsrc", 32'(bus.PCSrc), 32'd1);
    chk("beq_flush", 32'(bus.IFIDFlush), 32'd1);
    chk("beq_pcwrite", 32'(bus.PCWrite), 32'd1);
    tick();
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    chk("beq_bubble_aluop", 32'(bus.ALUOp_EX), 32'd0);
    chk("beq_bubble_regdst", 32'(bus.RegDst_EX), 32'd0);
    chk("beq_bubble_pcsrc", 32'(bus.PCSrc), 32'd0);
    tick();
    tick();
    chk("beq_bubble_no_wb", 32'(bus.RegWrite_WB), 32'd0);
    drain();
    // untaken branch
    id(BEQ, 3'b100, 5'd1, 5'd2, 5'd0);
    tick();
    id(RTYPE, 3'b111, 5'd3, 5'd4, 5'd5);
    bus.Zero_EX = 1'b0;
    #1;
    chk("bne_pcsrc", 32'(bus.PCSrc), 32'd0);
    chk("bne_flush", 32'(bus.IFIDFlush), 32'd0);
    tick();
    chk("bne_next_aluop", 32'(bus.ALUOp_EX), 32'd7);
    drain();
    // branch beats a simultaneous load-use hazard
    id(LWBR, 3'b100, 5'd0, 5'd6, 5'd0);
    tick();
    id(RTYPE, 3'b111, 5'd6, 5'd0, 5'd13);
    bus.Zero_EX = 1'b1;
    #1;
    chk("prio_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("prio_ifidwrite", 32'(bus.IFIDWrite), 32'd1);
    chk("prio_flush", 32'(bus.IFIDFlush), 32'd1);
    tick();
    bus.Zero_EX = 1'b0;
    chk("prio_bubble_aluop", 32'(bus.ALUOp_EX), 32'd0);
    drain();
    // reset with a store in flight
    id(RTYPE, 3'b111, 5'd1, 5'd2, 5'd7);
    tick();
    id(SW, 3'd0, 5'd1, 5'd3, 5'd0);
    tick();
    id(NOP, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("sw_memwrite_mem", 32'(bus.MemWrite_MEM), 32'd1);
    chk("sw_prev_regwrite_wb", 32'(bus.RegWrite_WB), 32'd1);
    reset = 1'b0;
    tick();
    chk("sw_rst_memwrite", 32'(bus.MemWrite_MEM), 32'd0);
    chk("sw_rst_regwrite", 32'(bus.RegWrite_WB), 32'd0);
    reset = 1'b1;
    tick();
    chk("sw_post_memwrite", 32'(bus.MemWrite_MEM), 32'd0);
    chk("sw_post_regwrite", 32'(bus.RegWrite_WB), 32'd0);
    // reset mid-stall discards the load in EX
    id(LW, 3'd0, 5'd1, 5'd8, 5'd0);
    tick();
    id(RTYPE, 3'b111, 5'd8, 5'd4, 5'd10);
    #1 chk("ms_stall", 32'(bus.PCWrite), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("ms_post_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("ms_post_ifidwrite", 32'(bus.IFIDWrite), 32'd1);
    tick();
    chk("ms_post_load_id", 32'(bus.ALUOp_EX), 32'd7);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
